// File: rtl/sr_pkg.sv
// Shared codes for the universal shift register and its frame FSM.
// The transmitter side uses the same shift-mode encoding.
package sr_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_DATA = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SR   = 2'b01;
  localparam logic [1:0] M_SL   = 2'b10;
  localparam logic [1:0] M_LD   = 2'b11;

endpackage

// File: rtl/unv_shreg_core.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Mode codes are shared with the transmitter.
module unv_shreg_core
  import sr_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic [1:0]   in_m,
  input  logic         in_sir,
  input  logic         in_sil,
  input  logic [W-1:0] in_l,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_q <= '0;
    end else begin
      case (in_m)
        M_SR:    r_q <= {in_sir, r_q[W-1:1]};
        M_SL:    r_q <= {r_q[W-2:0], in_sil};
        M_LD:    r_q <= in_l;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Start/stop framed serial receiver with selectable bit order.
// Good frames update o_q and the wrapping frame counter.
module sipo_frame_rx
  import sr_pkg::*;
#(
  parameter int W      = 4,
  parameter int FCNT_W = 8
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_sd,
  input  logic              in_sv,
  input  logic              in_dir,
  output logic [W-1:0]      o_q,
  output logic              o_vld,
  output logic              o_ferr,
  output logic              o_busy,
  output logic [FCNT_W-1:0] o_fcnt
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [1:0]    r_state;
  logic          r_dir;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_m;
  logic [W-1:0]  w_sh;

  // Shifting happens only on strobed data bits, in the latched order.
  always_comb begin
    w_m = M_HOLD;
    if (in_sv && r_state == S_DATA)
      w_m = r_dir ? M_SL : M_SR;
  end

  unv_shreg_core #(.W(W)) u_shreg (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .in_m   (w_m),
    .in_sir (in_sd),
    .in_sil (in_sd),
    .in_l   ('0),
    .o_q    (w_sh)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      o_q     <= '0;
      o_vld   <= 1'b0;
      o_ferr  <= 1'b0;
      o_fcnt  <= '0;
    end else begin
      o_vld  <= 1'b0;
      o_ferr <= 1'b0;
      if (in_sv) begin
        case (r_state)
          S_IDLE: begin
            if (!in_sd) begin
              r_state <= S_DATA;
              r_dir   <= in_dir;
              r_cnt   <= '0;
            end
          end
          S_DATA: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST)
              r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (in_sd) begin
              o_q    <= w_sh;
              o_vld  <= 1'b1;
              o_fcnt <= o_fcnt + 1'b1;
            end else begin
              o_ferr <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy = (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx with W=4.
// Frame table plus reset, abort and counter-wrap sequences.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sd;
  logic       sv;
  logic       dir;
  logic [3:0] q;
  logic       vld;
  logic       ferr;
  logic       busy;
  logic [7:0] fcnt;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  sipo_frame_rx #(.W(4), .FCNT_W(8)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .in_sd  (sd),
    .in_sv  (sv),
    .in_dir (dir),
    .o_q    (q),
    .o_vld  (vld),
    .o_ferr (ferr),
    .o_busy (busy),
    .o_fcnt (fcnt)
  );

  typedef struct {
    logic       dir;
    logic [3:0] data;
    logic       stop;
    int         gap;
    logic [3:0] eq;
    logic       ev;
    logic       ef;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic strobe(logic b);
    @(negedge clk);
    sd = b;
    sv = 1'b1;
    @(posedge clk);
    #1;
    sv = 1'b0;
    sd = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("gap_busy", busy, 1);
      chk("gap_novld", vld, 0);
    end
  endtask

  // Start, four data bits in the chosen order, then the stop bit.
  task automatic send_frame(logic d, logic [3:0] data, logic stp, int gap);
    logic b;
    dir = d;
    strobe(1'b0);
    chk("start_busy", busy, 1);
    chk("start_novld", vld, 0);
    dir = ~d;
    idle(gap);
    for (int i = 0; i < 4; i++) begin
      b = d ? data[3-i] : data[i];
      strobe(b);
      chk("data_busy", busy, 1);
      chk("data_novld", vld, 0);
      idle(gap);
    end
    strobe(stp);
  endtask

  initial begin
    rst = 1'b1;
    sd  = 1'b1;
    sv  = 1'b0;
    dir = 1'b0;

    tbl[0] = '{1'b0, 4'b0101, 1'b1, 0, 4'b0101, 1'b1, 1'b0, 8'd1};
    tbl[1] = '{1'b1, 4'b0101, 1'b1, 0, 4'b0101, 1'b1, 1'b0, 8'd2};
    tbl[2] = '{1'b0, 4'b0101, 1'b1, 3, 4'b0101, 1'b1, 1'b0, 8'd3};
    tbl[3] = '{1'b0, 4'b0011, 1'b0, 0, 4'b0101, 1'b0, 1'b1, 8'd3};
    tbl[4] = '{1'b0, 4'b1100, 1'b1, 0, 4'b1100, 1'b1, 1'b0, 8'd4};
    tbl[5] = '{1'b1, 4'b1110, 1'b1, 2, 4'b1110, 1'b1, 1'b0, 8'd5};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst0_q", q, 0);
    chk("rst0_fcnt", fcnt, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sv  = 1'($urandom_range(0, 1));
      sd  = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    sv  = 1'b1;
    sd  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sv  = 1'b0;
    sd  = 1'b1;
    chk("rst1_q", q, 0);
    chk("rst1_vld", vld, 0);
    chk("rst1_ferr", ferr, 0);
    chk("rst1_busy", busy, 0);
    chk("rst1_fcnt", fcnt, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dir, tbl[i].data, tbl[i].stop, tbl[i].gap);
      chk($sformatf("v%0d_q", i), q, tbl[i].eq);
      chk($sformatf("v%0d_vld", i), vld, tbl[i].ev);
      chk($sformatf("v%0d_ferr", i), ferr, tbl[i].ef);
      chk($sformatf("v%0d_fcnt", i), fcnt, tbl[i].ec);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    @(negedge clk);
    @(posedge clk);
    #1;
    chk("pulse_vld_clr", vld, 0);
    chk("pulse_ferr_clr", ferr, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_q", q, 4'b1110);

    dir = 1'b1;
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_q", q, 0);
    chk("abort_fcnt", fcnt, 0);

    send_frame(1'b1, 4'b1001, 1'b1, 0);
    chk("r6_q", q, 4'b1001);
    chk("r6_vld", vld, 1);
    chk("r6_fcnt", fcnt, 1);

    for (int i = 0; i < 255; i++)
      send_frame(1'b0, 4'(i), 1'b1, 0);
    chk("wrap_fcnt", fcnt, 0);
    chk("wrap_vld", vld, 1);
    chk("wrap_q", q, 4'hE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
